// File: rtl/blksync_pkg.sv
// Shared types and helpers for the toggle-pattern stream checker.
package blksync_pkg;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [7:0] ERR_MAX = 8'd255;

  // Widest sample the helper supports; callers cast down to their own width.
  localparam int INV_MAXW = 64;

  // Expected successor of a sample in the ~v register pattern.
  function automatic logic [INV_MAXW-1:0] f_inv(input logic [INV_MAXW-1:0] v);
    return ~v;
  endfunction

endpackage

// File: rtl/blksync_stream_checker_if.sv
// Valid/ready sample stream between the register-producing stage and the checker.
interface blksync_stream_checker_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/blksync_fifo.sv
// Small synchronous FIFO, no fall-through. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
module blksync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  // Pointer update; flush discards everything including a same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + (AW+1)'(1);
      if (pop_ok)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/blksync_stream_checker.sv
// Buffers a sample stream and checks each sample is the bitwise inverse of
// the one accepted before it. Reports done/pass/error count after a run.
module blksync_stream_checker
  import blksync_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int NUM_SAMPLES = 20,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  blksync_stream_checker_if.slave         stream,
  input  logic                            chk_en,
  input  logic                            restart,
  output logic                            done,
  output logic                            pass,
  output logic [7:0]                      err_cnt,
  output logic [15:0]                     sample_cnt
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [7:0]       err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             push, pop;
  logic [WIDTH-1:0] exp_data;
  logic             mismatch;

  // in_ready comes straight from registered pointers; restart drops the push.
  assign stream.in_ready = !fifo_full;
  assign push = stream.in_valid && !fifo_full && !restart;
  assign pop  = chk_en && !fifo_empty && (state_q != ST_DONE) && !restart;

  blksync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (restart),
    .push  (push),
    .pop   (pop),
    .din   (stream.in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign exp_data = WIDTH'(f_inv(INV_MAXW'(prev_q)));
  assign mismatch = (fifo_dout != exp_data);

  // Next-state, counters and compare; restart overrides everything.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (restart) begin
      state_d = ST_SEED;
      prev_d  = '0;
      err_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_SEED: begin
          if (pop) begin
            prev_d  = fifo_dout;
            cnt_d   = 16'd1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pop) begin
            // Track the actual sample so one bad value costs at most two errors.
            prev_d = fifo_dout;
            if (mismatch && (err_q != ERR_MAX)) err_d = err_q + 8'd1;
            cnt_d = cnt_q + 16'd1;
            if (cnt_d == 16'(NUM_SAMPLES)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              pass_d  = (err_d == 8'd0);
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_SEED;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEED;
      prev_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign done       = done_q;
  assign pass       = pass_q && done_q;
  assign err_cnt    = err_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_blksync_stream_checker.sv
// Directed-plus-random bench for blksync_stream_checker with a queue-based model.
module tb_blksync_stream_checker;

  localparam int W     = 4;
  localparam int NUM   = 20;
  localparam int DEPTH = 4;
  localparam int NUM2  = 300;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en, restart, done, pass;
  logic [7:0]  err_cnt;
  logic [15:0] sample_cnt;

  logic chk2, restart2, done2, pass2;
  logic [7:0]  err2;
  logic [15:0] cnt2;

  always #5 clk = ~clk;

  blksync_stream_checker_if #(.WIDTH(W)) sif ();
  blksync_stream_checker_if #(.WIDTH(1)) sif2 ();

  blksync_stream_checker #(.WIDTH(W), .NUM_SAMPLES(NUM), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stream(sif.slave), .chk_en(chk_en), .restart(restart),
    .done(done), .pass(pass), .err_cnt(err_cnt), .sample_cnt(sample_cnt));

  blksync_stream_checker #(.WIDTH(1), .NUM_SAMPLES(NUM2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst_n(rst_n), .stream(sif2.slave), .chk_en(chk2), .restart(restart2),
    .done(done2), .pass(pass2), .err_cnt(err2), .sample_cnt(cnt2));

  // Model: FIFO contents and the samples consumed in this run.
  logic [W-1:0] q[$];
  logic [W-1:0] cons[$];
  int checks = 0;
  int failures = 0;

  // Producer: toggle stream from a seed, optionally one corrupted sample.
  int           gen_k;
  logic [W-1:0] gen_seed;
  int           bad_k;
  logic [W-1:0] bad_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_err();
    int n = 0;
    for (int i = 1; i < cons.size(); i++)
      if (cons[i] !== ~cons[i-1]) n++;
    return (n > 255) ? 255 : n;
  endfunction

  function automatic logic [W-1:0] gen_data();
    logic [W-1:0] b;
    b = (gen_k % 2 == 1) ? ~gen_seed : gen_seed;
    return (gen_k == bad_k) ? (b ^ bad_mask) : b;
  endfunction

  task automatic new_run(input logic [W-1:0] seed, input int bad);
    gen_k    = 0;
    gen_seed = seed;
    bad_k    = bad;
    bad_mask = W'($urandom_range(1, (1 << W) - 1));
  endtask

  task automatic check_all();
    logic m_done;
    int   e;
    m_done = (cons.size() == NUM);
    e = model_err();
    chk("in_ready", 32'(sif.in_ready), 32'(q.size() < DEPTH));
    chk("done", 32'(done), 32'(m_done));
    chk("pass", 32'(pass), 32'(m_done && e == 0));
    chk("err_cnt", 32'(err_cnt), 32'(e));
    chk("sample_cnt", 32'(sample_cnt), 32'(cons.size()));
  endtask

  // One clock: drive, advance model at the edge, check at the falling edge.
  task automatic cyc(input logic v, input logic c, input logic rs, output logic [W-1:0] d);
    logic psh, pp;
    d = gen_data();
    sif.in_valid = v;
    sif.in_data  = d;
    chk_en       = c;
    restart      = rs;
    psh = v && (q.size() < DEPTH) && !rs;
    pp  = c && (q.size() > 0) && (cons.size() != NUM) && !rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      cons.delete();
    end else begin
      if (pp) cons.push_back(q.pop_front());
      if (psh) q.push_back(d);
    end
    if (psh) gen_k++;
    @(negedge clk);
    check_all();
  endtask

  // Run with given valid/chk_en probabilities (percent) until done or bound.
  task automatic run_to_done(input string tag, input int pv, input int pc, input int bound);
    logic [W-1:0] d;
    int n = 0;
    while (cons.size() != NUM && n < bound) begin
      cyc($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pc, 1'b0, d);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cnt"}, 32'(sample_cnt), NUM);
  endtask

  initial begin
    logic [W-1:0] d, dropped;
    int k;
    rst_n = 1'b0;
    sif.in_valid = 1'b0; sif.in_data = '0; chk_en = 1'b0; restart = 1'b0;
    sif2.in_valid = 1'b0; sif2.in_data = 1'b1; chk2 = 1'b0; restart2 = 1'b0;
    new_run('0, -1);
    #3;
    chk("rst_ready", 32'(sif.in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Clean toggle run, continuous flow.
    new_run(W'($urandom), -1);
    run_to_done("clean", 100, 100, 40);
    chk("clean_pass", 32'(pass), 32'd1);
    chk("clean_err", 32'(err_cnt), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, d);
    chk("clean_hold", 32'(sample_cnt), NUM);

    // Sample 7 corrupted: two errors, still done after 20.
    cyc(1'b0, 1'b0, 1'b1, d);
    new_run(W'($urandom), 6);
    run_to_done("bad7", 80, 100, 80);
    chk("bad7_err", 32'(err_cnt), 32'd2);
    chk("bad7_pass", 32'(pass), 32'd0);

    // Backpressure: fill without popping, then drain.
    cyc(1'b0, 1'b0, 1'b1, d);
    new_run(W'($urandom), -1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, d);
    chk("bp_full", 32'(sif.in_ready), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, d);
    chk("bp_ready_back", 32'(sif.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, d);
    chk("bp_drained", 32'(sample_cnt), 32'd4);

    // Restart at sample_cnt 10 with a valid sample that must be dropped.
    cyc(1'b0, 1'b0, 1'b1, d);
    new_run(W'($urandom), -1);
    k = 0;
    while (sample_cnt != 16'd10 && k < 40) begin
      cyc(1'b1, 1'b1, 1'b0, d);
      k++;
    end
    chk("rs_reach10", 32'(sample_cnt), 32'd10);
    cyc(1'b1, 1'b1, 1'b1, dropped);
    chk("rs_cnt", 32'(sample_cnt), 32'd0);
    chk("rs_err", 32'(err_cnt), 32'd0);
    chk("rs_empty", 32'(sif.in_ready), 32'd1);
    new_run(dropped, -1);
    run_to_done("rs_after", 100, 100, 40);
    chk("rs_after_pass", 32'(pass), 32'd1);

    // Asynchronous reset mid-run.
    cyc(1'b0, 1'b0, 1'b1, d);
    new_run(W'($urandom), -1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, d);
    chk("ar_busy", 32'(sample_cnt != 0), 32'd1);
    #2;
    rst_n = 1'b0; sif.in_valid = 1'b0; chk_en = 1'b0;
    #1;
    chk("ar_ready", 32'(sif.in_ready), 32'd1);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_err", 32'(err_cnt), 32'd0);
    chk("ar_cnt", 32'(sample_cnt), 32'd0);
    q.delete(); cons.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_all();
    new_run(W'($urandom), -1);
    run_to_done("ar_after", 100, 100, 40);
    chk("ar_after_pass", 32'(pass), 32'd1);

    // Random runs: random flow control, occasional corrupted sample.
    for (int r = 0; r < 4; r++) begin
      cyc(1'b0, 1'b0, 1'b1, d);
      new_run(W'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NUM - 1)) : -1);
      run_to_done("rand", 70, 60, 300);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, d);
    end

    // Long constant-ones run on the second instance: saturating errors.
    restart2 = 1'b1;
    @(posedge clk); @(negedge clk);
    restart2 = 1'b0;
    chk("sat_start_ready", 32'(sif2.in_ready), 32'd1);
    sif2.in_valid = 1'b1; sif2.in_data = 1'b1; chk2 = 1'b1;
    for (int i = 0; i <= 302; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 100) chk("sat_err100", 32'(err2), 32'd99);
      if (i == 256) chk("sat_err256", 32'(err2), 32'd255);
      if (i == 299) chk("sat_not_done", 32'(done2), 32'd0);
      if (i == 300) begin
        chk("sat_done", 32'(done2), 32'd1);
        chk("sat_err", 32'(err2), 32'd255);
        chk("sat_cnt", 32'(cnt2), NUM2);
        chk("sat_pass", 32'(pass2), 32'd0);
      end
    end
    chk("sat_hold", 32'(cnt2), NUM2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
